serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Sequencer for the bit-serial adder. It accepts parallel WIDTH-bit operand pairs over a valid/ready handshake and clears the adder's carry. It then feeds operand bits LSB-first for WIDTH cycles and reassembles the serial sum bits into a parallel result, which it presents on a valid/ready output. It sits between parallel producers/consumers and the external serial adder datapath, which stays a separate instance.

## Interface
- WIDTH, 4: operand/result width in bits; legal values 2 to 32.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  sum bits.
- out_cout  output  1  final carry out.
- out_ovf  output  1  signed overflow; present only with SERIAL_ADD_CTRL_OVF_EN.
- busy  output  1  high in any state other than IDLE.
- sa_clr  output  1  carry clear to the serial adder (drives its rst).
- sa_a  output  1  current A bit to the adder.
- sa_b  output  1  current B bit to the adder.
- sa_f  input  1  adder sum bit, combinational from sa_a, sa_b and carry state.
- sa_cout  input  1  adder carry out of the current bit, combinational.

## Operation
- States: IDLE, CLR, SHIFT, DONE. The reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_a and in_b into shift registers, clear bit counter, go to CLR.
- CLR:
  - sa_clr=1 for exactly one cycle; the adder carry is zero at the next edge.
  - Go to SHIFT.
- SHIFT:
  - sa_a and sa_b are the operand shift registers' bit 0.
  - Each edge: shift both operands right, shift sa_f into the result register at its MSB (result LSB-aligned after WIDTH shifts), increment the counter.
  - On the edge where counter==WIDTH-1: capture sa_cout into out_cout and go to DONE.
- DONE:
  - out_valid=1; out_sum and out_cout stay stable.
  - On out_ready: go to IDLE. out_sum and out_cout keep their value until the next capture.
- sa_clr = rst | (state==CLR). The adder carry is therefore cleared whenever the controller is reset.
- sa_a and sa_b are 0 outside SHIFT.
- in_valid outside IDLE is ignored; the operands are not latched.
- Arithmetic: unsigned modulo 2^WIDTH; the carry is reported separately.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0, sa_a=0, sa_b=0, sa_clr=1 while rst is high.
- Accept on edge k:
  - CLR during cycle k+1.
  - SHIFT during cycles k+2 to k+1+WIDTH.
  - out_valid high from cycle k+2+WIDTH.
- With out_ready held high, out_valid lasts one cycle and in_ready returns the following cycle. The minimum issue interval is WIDTH+3 cycles.
- There is no bypass from out_ready to in_ready in the same cycle.
- rst mid-operation (any state):
  - Abort the operation, return to IDLE, clear all registers.
  - No out_valid pulse for the aborted operation.

## Configuration
- SERIAL_ADD_CTRL_OVF_EN defined:
  - out_ovf port exists.
  - On the last SHIFT bit, out_ovf captures (sa_a^sa_b^sa_f)^sa_cout, i.e. carry into the MSB XOR carry out.
  - out_ovf is valid with out_valid.
- Not defined:
  - The port and its register are absent.
  - All other behaviour is identical.

## Structure
- Shared package serial_pkg holds:
  - State enum (IDLE, CLR, SHIFT, DONE).
  - Default width constant SERIAL_WIDTH=4.
  - Counter width derived via $clog2(WIDTH).
- One sub-module, serial_shift_reg, a parameterized shift-right register with parallel load, serial in and serial out:
  - Instantiated twice for the operands, with parallel load and serial out.
  - Instantiated once for the result, with serial in and parallel out.
- The FSM and counter live in serial_add_ctrl.

## Test plan
All scenarios use WIDTH=4, driven with a behavioural serial adder model.
- 5+3 accepted on edge k, out_ready high: out_valid at cycle k+6, out_sum=8, out_cout=0, then in_ready=1.
- 15+1: out_sum=0, out_cout=1. With SERIAL_ADD_CTRL_OVF_EN, 7+1 gives out_ovf=1 and 3+2 gives out_ovf=0.
- out_ready held low 5 cycles after out_valid: out_valid, out_sum and out_cout stay stable, in_ready stays 0, new in_valid is ignored. Release gives one handshake.
- in_valid held high with changing operands during SHIFT: the result reflects only the operands latched at accept.
- rst asserted for one cycle in the middle of SHIFT: next cycle is IDLE with in_ready=1 and out_valid=0. The following 9+6 returns 15, carry 0, so no stale carry remains.
- Back-to-back: all 256 operand pairs with out_ready random: every result equals (a+b) mod 16 with the correct carry, and accepts are spaced at least 7 cycles apart.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_pkg;

  localparam int unsigned SERIAL_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit-counter width for a given operand width (never below one bit).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Shift-right register with parallel load, serial in at the MSB and serial out from the LSB.
module serial_shift_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

  assign sout = q[0];

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer feeding an external bit-serial adder and reassembling its parallel result.
// Optional signed-overflow output enabled by defining SERIAL_ADD_CTRL_OVF_EN.
module serial_add_ctrl
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef SERIAL_ADD_CTRL_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy,
  output logic             sa_clr,
  output logic             sa_a,
  output logic             sa_b,
  input  logic             sa_f,
  input  logic             sa_cout
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             shift;
  logic             last;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             a_bit;
  logic             b_bit;
  logic             res_sout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = CLR;
        end
      end
      CLR: begin
        state_nxt = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sa_clr    = rst | (state == CLR);
  assign sa_a      = (state == SHIFT) & a_bit;
  assign sa_b      = (state == SHIFT) & b_bit;

  serial_shift_reg #(.WIDTH(WIDTH)) u_a_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (in_a),
    .sin   (1'b0),
    .q     (a_q),
    .sout  (a_bit)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_b_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (in_b),
    .sin   (1'b0),
    .q     (b_q),
    .sout  (b_bit)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_res_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (1'b0),
    .shift (shift),
    .din   ('0),
    .sin   (sa_f),
    .q     (res_q),
    .sout  (res_sout)
  );

  // Operand parallel outputs and result serial out are not needed here.
  logic unused_ok;
  assign unused_ok = ^{a_q, b_q, res_sout};

  // Result is snapshotted on the last bit so it holds until the next capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      if (load) begin
        cnt <= '0;
      end else if (shift) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (last) begin
        out_sum  <= {sa_f, res_q[WIDTH-1:1]};
        out_cout <= sa_cout;
      end
    end
  end

`ifdef SERIAL_ADD_CTRL_OVF_EN
  // Carry into the MSB is recovered as a^b^f; overflow when it differs from carry out.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ovf <= 1'b0;
    end else if (last) begin
      out_ovf <= (sa_a ^ sa_b ^ sa_f) ^ sa_cout;
    end
  end
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a behavioural bit-serial adder attached.
// Overflow checks are included when SERIAL_ADD_CTRL_OVF_EN is defined.
module tb_serial_add_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef SERIAL_ADD_CTRL_OVF_EN
  logic         out_ovf;
`endif
  logic         busy;
  logic         sa_clr;
  logic         sa_a;
  logic         sa_b;
  logic         sa_f;
  logic         sa_cout;

  logic         carry;
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef SERIAL_ADD_CTRL_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .busy      (busy),
    .sa_clr    (sa_clr),
    .sa_a      (sa_a),
    .sa_b      (sa_b),
    .sa_f      (sa_f),
    .sa_cout   (sa_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural serial adder: one carry flop cleared by sa_clr.
  always @(posedge clk) carry <= sa_clr ? 1'b0 : sa_cout;
  assign sa_f    = sa_a ^ sa_b ^ carry;
  assign sa_cout = (sa_a & sa_b) | (carry & (sa_a ^ sa_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // One operation; noisy keeps in_valid high with junk operands, hold stalls out_ready.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit noisy, input int hold);
    logic [W:0] s;
    logic       ovf;
    s   = (W+1)'(a) + (W+1)'(b);
    ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    wait_ready();
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    check("clr_pulse", 32'(sa_clr), 32'd1);
    check("busy_clr", 32'(busy), 32'd1);
    check("in_ready_clr", 32'(in_ready), 32'd0);
    if (!noisy) in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (noisy) begin
        in_a = W'($urandom);
        in_b = W'($urandom);
      end
      tick();
      if (i == 0) begin
        check("sa_a_bit0", 32'(sa_a), 32'(a[0]));
        check("sa_b_bit0", 32'(sa_b), 32'(b[0]));
        check("sa_clr_shift", 32'(sa_clr), 32'd0);
      end
      if (i == W - 1) check("no_early_valid", 32'(out_valid), 32'd0);
    end
    tick();
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_sum", 32'(out_sum), 32'(s[W-1:0]));
    check("out_cout", 32'(out_cout), 32'(s[W]));
`ifdef SERIAL_ADD_CTRL_OVF_EN
    check("out_ovf", 32'(out_ovf), 32'(ovf));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(out_sum), 32'(s[W-1:0]));
      check("hold_cout", 32'(out_cout), 32'(s[W]));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int last_acc;
    int n;
    bit hs;
    bit r;
    logic [W:0] s;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_cout", 32'(out_cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sa_a", 32'(sa_a), 32'd0);
    check("rst_sa_b", 32'(sa_b), 32'd0);
    check("rst_sa_clr", 32'(sa_clr), 32'd1);
`ifdef SERIAL_ADD_CTRL_OVF_EN
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
`endif
    rst = 1'b0;
    tick();
    check("idle_sa_clr", 32'(sa_clr), 32'd0);

    run_op(4'd5, 4'd3, 1'b0, 0);
    run_op(4'd15, 4'd1, 1'b0, 0);
    run_op(4'd7, 4'd1, 1'b0, 0);
    run_op(4'd3, 4'd2, 1'b0, 0);
    run_op(4'd10, 4'd12, 1'b0, 5);
    run_op(4'd2, 4'd9, 1'b1, 0);

    // Abort mid-SHIFT with a live carry, then confirm a clean restart.
    wait_ready();
    in_a     = 4'd15;
    in_b     = 4'd15;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("abort_sa_clr", 32'(sa_clr), 32'd1);
    tick();
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_sum", 32'(out_sum), 32'd0);
    repeat (6) tick();
    check("abort_no_valid", 32'(out_valid), 32'd0);
    run_op(4'd9, 4'd6, 1'b0, 0);

    // All operand pairs, random out_ready, accept spacing tracked.
    last_acc = -100;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        s = 5'(a) + 5'(b);
        wait_ready();
        in_a     = W'(a);
        in_b     = W'(b);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("b2b_spacing", 32'(cyc - last_acc >= 7), 32'd1);
        last_acc = cyc;
        n = 0;
        while (!out_valid && n < 20) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
          n++;
        end
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_sum", 32'(out_sum), 32'(s[W-1:0]));
        check("b2b_cout", 32'(out_cout), 32'(s[W]));
        n  = 0;
        hs = 1'b0;
        do begin
          r         = 1'($urandom_range(0, 1));
          out_ready = r;
          hs        = out_valid && r;
          tick();
          n++;
        end while (!hs && n < 50);
        check("b2b_handshake", 32'(hs), 32'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
